// File: rtl/demux_deser.sv
// demux_deser -- serial-to-parallel frame assembler (1:4 demultiplexer).
//
// Accepts one WIDTH-bit sample per din_valid cycle and places it into slot
// lane_sel of a 4-lane shadow register. When the sample for lane 3 is
// accepted, the complete frame is loaded into dout on that edge and
// dout_valid pulses for one cycle. sync=1 on an accepted sample restarts
// the frame at lane 0 and discards any partial frame.
//
// Optional feature (macro DEMUX_ERR_EN): sync_err / err_cnt report sync
// markers that arrive while a frame is partially assembled.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   din         in   [WIDTH]    serial sample
//   din_valid   in   sample qualifier
//   sync        in   frame alignment marker (qualified by din_valid)
//   dout        out  [4*WIDTH]  assembled frame, lane k at [k*WIDTH +: WIDTH]
//   dout_valid  out  one-cycle pulse on new dout
//   lane_sel    out  [2]        slot for the next accepted sample
//   sync_err    out  sticky misalignment flag       (DEMUX_ERR_EN only)
//   err_cnt     out  [8] saturating misalign count  (DEMUX_ERR_EN only)

module demux_deser #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [4*WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic [1:0]         lane_sel
`ifdef DEMUX_ERR_EN
  ,
  output logic               sync_err,
  output logic [7:0]         err_cnt
`endif
);

  logic [3:0][WIDTH-1:0] shadow;
  logic [3:0][WIDTH-1:0] frame;

  // Shadow contents with the current sample merged into its slot; this is
  // both the next shadow value and, on a lane-3 accept, the full frame.
  always_comb begin
    frame           = shadow;
    frame[lane_sel] = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_sel   <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid) begin
        if (sync) begin
          // Realign: sample is lane 0, even if lane 3 was expected.
          shadow[0] <= din;
          lane_sel  <= 2'd1;
        end else begin
          shadow   <= frame;
          lane_sel <= lane_sel + 2'd1;
          if (lane_sel == 2'd3) begin
            dout       <= frame;
            dout_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DEMUX_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else if (din_valid && sync && (lane_sel != 2'd0)) begin
      sync_err <= 1'b1;
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_deser.sv
// Testbench for demux_deser (WIDTH=1): a table of directed vectors for the
// framing corner cases, a randomized run against a queue-based frame model,
// and (with DEMUX_ERR_EN) an error-counter saturation sequence.

module tb_demux_deser;

  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           sync = 1'b0;
  logic [4*W-1:0] dout;
  logic           dout_valid;
  logic [1:0]     lane_sel;
`ifdef DEMUX_ERR_EN
  logic           sync_err;
  logic [7:0]     err_cnt;
`endif

  demux_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .lane_sel   (lane_sel)
`ifdef DEMUX_ERR_EN
    ,
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic       sync;
    logic       din;
    logic [3:0] dout;
    logic       valid;
    logic [1:0] lane;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic s, input logic d,
                     input logic [3:0] o, input logic ov, input logic [1:0] l,
                     input logic e, input logic [7:0] c);
    vec_t t;
    t.rst_n = r; t.dv = v; t.sync = s; t.din = d;
    t.dout = o; t.valid = ov; t.lane = l; t.err = e; t.cnt = c;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    rst_n = r; din_valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the partial frame is a queue of accepted samples.
  logic [W-1:0] mq[$];
  logic [3:0]   m_dout;
  logic         m_valid;
  logic         m_err;
  int           m_cnt;

  task automatic model(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    if (!r) begin
      mq.delete(); m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_valid = 1'b0;
      if (v) begin
        if (s) begin
          if (mq.size() != 0) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          mq.delete();
        end
        mq.push_back(d);
        if (mq.size() == 4) begin
          for (int k = 0; k < 4; k++) m_dout[k] = mq[k];
          m_valid = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  initial begin
    // reset, then aligned frame 0,1,0,1 -> 1010
    add(0,0,0,0, 4'b0000,0,0, 0,0);
    add(1,1,1,0, 4'b0000,0,1, 0,0);
    add(1,1,0,1, 4'b0000,0,2, 0,0);
    add(1,1,0,0, 4'b0000,0,3, 0,0);
    add(1,1,0,1, 4'b1010,1,0, 0,0);
    add(1,0,0,0, 4'b1010,0,0, 0,0);
    // back-to-back 1,1,0,0,0,0,1,1 -> 0011 then 1100
    add(1,1,0,1, 4'b1010,0,1, 0,0);
    add(1,1,0,1, 4'b1010,0,2, 0,0);
    add(1,1,0,0, 4'b1010,0,3, 0,0);
    add(1,1,0,0, 4'b0011,1,0, 0,0);
    add(1,1,0,0, 4'b0011,0,1, 0,0);
    add(1,1,0,0, 4'b0011,0,2, 0,0);
    add(1,1,0,1, 4'b0011,0,3, 0,0);
    add(1,1,0,1, 4'b1100,1,0, 0,0);
    // gaps (ignored din/sync) around 1,0,...,1,1 -> 1101
    add(1,1,0,1, 4'b1100,0,1, 0,0);
    add(1,0,1,0, 4'b1100,0,1, 0,0);
    add(1,1,0,0, 4'b1100,0,2, 0,0);
    add(1,0,1,1, 4'b1100,0,2, 0,0);
    add(1,0,0,0, 4'b1100,0,2, 0,0);
    add(1,1,0,1, 4'b1100,0,3, 0,0);
    add(1,1,0,1, 4'b1101,1,0, 0,0);
    // two samples, sync mid-frame, then 0,0,0 -> 0001
    add(1,1,0,1, 4'b1101,0,1, 0,0);
    add(1,1,0,1, 4'b1101,0,2, 0,0);
    add(1,1,1,1, 4'b1101,0,1, 1,1);
    add(1,1,0,0, 4'b1101,0,2, 1,1);
    add(1,1,0,0, 4'b1101,0,3, 1,1);
    add(1,1,0,0, 4'b0001,1,0, 1,1);
    // sync where lane 3 was expected: no pulse, restarts -> 1010
    add(1,1,0,0, 4'b0001,0,1, 1,1);
    add(1,1,0,1, 4'b0001,0,2, 1,1);
    add(1,1,0,1, 4'b0001,0,3, 1,1);
    add(1,1,1,0, 4'b0001,0,1, 1,2);
    add(1,1,0,1, 4'b0001,0,2, 1,2);
    add(1,1,0,0, 4'b0001,0,3, 1,2);
    add(1,1,0,1, 4'b1010,1,0, 1,2);
    // reset after two samples beats a simultaneous valid; then clean frame 1001
    add(1,1,0,1, 4'b1010,0,1, 1,2);
    add(1,1,0,0, 4'b1010,0,2, 1,2);
    add(0,1,0,1, 4'b0000,0,0, 0,0);
    add(1,1,0,1, 4'b0000,0,1, 0,0);
    add(1,1,0,0, 4'b0000,0,2, 0,0);
    add(1,1,0,0, 4'b0000,0,3, 0,0);
    add(1,1,0,1, 4'b1001,1,0, 0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].dv, tbl[i].sync, tbl[i].din);
      chk($sformatf("tbl%0d.dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d.valid", i), 32'(dout_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d.lane", i), 32'(lane_sel), 32'(tbl[i].lane));
`ifdef DEMUX_ERR_EN
      chk($sformatf("tbl%0d.sync_err", i), 32'(sync_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
`endif
    end

    // Randomized run against the queue model.
    model(0, 0, 0, '0);
    step(0, 0, 0, '0);
    for (int c = 0; c < 3000; c++) begin
      logic r, v, s;
      logic [W-1:0] d;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      d = W'($urandom);
      model(r, v, s, d);
      step(r, v, s, d);
      chk($sformatf("rnd%0d.dout", c), 32'(dout), 32'(m_dout));
      chk($sformatf("rnd%0d.valid", c), 32'(dout_valid), 32'(m_valid));
      chk($sformatf("rnd%0d.lane", c), 32'(lane_sel), 32'(mq.size()));
`ifdef DEMUX_ERR_EN
      chk($sformatf("rnd%0d.sync_err", c), 32'(sync_err), 32'(m_err));
      chk($sformatf("rnd%0d.err_cnt", c), 32'(err_cnt), 32'(m_cnt));
`endif
    end

    // 300 misaligned syncs: the counter stops at 255.
    step(0, 0, 0, '0);
    step(1, 1, 0, '0);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1, W'($urandom));
`ifdef DEMUX_ERR_EN
      if (i == 253) chk("sat.err_cnt_254", 32'(err_cnt), 32'd254);
      if (i == 254) chk("sat.err_cnt_255", 32'(err_cnt), 32'd255);
`endif
    end
    chk("sat.lane", 32'(lane_sel), 32'd1);
    chk("sat.valid", 32'(dout_valid), 32'd0);
`ifdef DEMUX_ERR_EN
    chk("sat.err_cnt_end", 32'(err_cnt), 32'd255);
    chk("sat.sync_err", 32'(sync_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/demux_deser.md
DEMUX_DESER -- requirements
Module: demux_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning bit width of each sample and lane.
REQ-002 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n, input, 1, the synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have din, input, WIDTH, the serial sample stream; lane k of the frame arrives in slot k.
REQ-005 SHALL have din_valid, input, 1, qualifier; din is accepted only in cycles with din_valid=1.
REQ-006 SHALL have sync, input, 1, frame alignment marker; meaningful only when din_valid=1.
REQ-007 SHALL have dout, output, 4*WIDTH, the assembled frame; lane k occupies dout[k*WIDTH +: WIDTH].
REQ-008 SHALL have dout_valid, output, 1, a one-cycle pulse marking a new dout.
REQ-009 SHALL have lane_sel, output, 2, the slot index the next accepted sample will occupy.
REQ-010 SHALL have, only with DEMUX_ERR_EN, sync_err (output, 1, sticky misalignment flag) and err_cnt (output, 8, count of misalignment events).

Function
REQ-011 SHALL hold an internal 2-bit slot counter driving lane_sel and a 4-lane shadow register.
REQ-012 SHALL, on an accepted sample with sync=0, write din into shadow lane lane_sel and increment lane_sel modulo 4.
REQ-013 SHALL, on an accepted sample with sync=1, write din into shadow lane 0 and set lane_sel to 1, discarding any partial frame.
REQ-014 SHALL, when the accepted sample fills lane 3, load dout from the shadow lanes 0..2 plus that lane-3 sample on the next rising edge and pulse dout_valid high for exactly that one cycle.
REQ-015 SHALL give a latency of 1 clk from the lane-3 accept edge to dout/dout_valid visible.
REQ-016 SHALL hold dout unchanged between frames; dout_valid SHALL be 0 in all other cycles.
REQ-017 SHALL ignore din and sync entirely in cycles with din_valid=0; no state changes.
REQ-018 SHALL support back-to-back frames: a lane-3 accept followed immediately by a lane-0 accept, with no idle cycles, producing dout_valid every 4th accepted cycle.
REQ-019 SHALL treat sync=1 arriving while lane_sel=0 as a normal aligned frame start, not an error.
REQ-020 SHALL not partition the frame on sync=1 with lane_sel=3 accepted: the sample goes to lane 0 and no dout_valid is produced.

Reset
REQ-021 SHALL, when rst_n=0 at a rising clk edge, clear lane_sel to 0, the shadow register to 0, dout to 0 and dout_valid to 0.
REQ-022 SHALL, with DEMUX_ERR_EN, also clear sync_err to 0 and err_cnt to 0 on reset.
REQ-023 SHALL give reset priority over any simultaneous din_valid/sync; a mid-frame reset discards the partial frame.

Configuration
REQ-024 SHALL, when macro DEMUX_ERR_EN is defined, set sync_err and increment err_cnt on every accepted sync=1 with lane_sel!=0.
REQ-025 SHALL saturate err_cnt at 255, with no wrap-around.
REQ-026 SHALL, without DEMUX_ERR_EN, omit the sync_err and err_cnt ports and logic; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover this case: reset, then sync=1 with din 0,1,0,1 over 4 consecutive valid cycles (WIDTH=1) -> dout=4'b1010 and a single dout_valid pulse 1 cycle after the 4th sample.
REQ-028 SHALL cover this case: 8 back-to-back samples 1,1,0,0,0,0,1,1 -> dout=4'b0011 then 4'b1100, with dout_valid exactly 4 cycles apart.
REQ-029 SHALL cover this case: samples 1,0 interleaved with din_valid=0 gap cycles, then 1,1 -> dout=4'b1101, lane_sel stable during gaps.
REQ-030 SHALL cover this case: 2 samples, then sync=1 sample 1, then 0,0,0 -> dout=4'b0001, no pulse for the aborted frame; with DEMUX_ERR_EN, sync_err=1 and err_cnt=1.
REQ-031 SHALL cover this case: rst_n=0 asserted after 2 accepted samples -> lane_sel=0, dout=0, dout_valid=0 next cycle; the next 4 samples form a clean frame.
REQ-032 SHALL cover this case: with DEMUX_ERR_EN, 300 misaligned sync events -> err_cnt=255, sync_err=1.
